// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
//
// This block drives the single write port of the 32-entry register file.
// Two sources share that port:
//   - the main pipeline writeback, which takes one cycle and has priority;
//   - the multiply/divide unit (MDU). Its results are held in a small
//     in-order FIFO and written when the main pipe leaves the port idle.
// A starvation guard raises stall_req when queued MDU results cannot drain.
//
// Optional feature: define WB_MDU_BYPASS_EN to let an MDU result go straight
// to the output stage. This happens when the FIFO is empty and the port is
// idle, and it cuts the latency from at least 2 cycles to 1.
//
// Ports:
//   clk, reset (async, active-low)
//   wb_valid/wb_addr/wb_data          main-pipe write request (never stalled)
//   mdu_valid/mdu_ready/mdu_addr/...  MDU result handshake
//   RegWrite/write_address/write_data registered register-file write port
//   mdu_pending                       FIFO non-empty (for the hazard unit)
//   fifo_count                        FIFO occupancy
//   stall_req                         registered request to hold wb_valid=0
module reg_writeback_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wb_valid,
    input  logic [4:0]                  wb_addr,
    input  logic [DATA_WIDTH-1:0]       wb_data,
    input  logic                        mdu_valid,
    output logic                        mdu_ready,
    input  logic [4:0]                  mdu_addr,
    input  logic [DATA_WIDTH-1:0]       mdu_data,
    output logic                        RegWrite,
    output logic [4:0]                  write_address,
    output logic [DATA_WIDTH-1:0]       write_data,
    output logic                        mdu_pending,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        stall_req
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // FIFO storage. Only the pointers are reset; stale contents are never
    // read because occupancy gates every pop.
    logic [4:0]            mem_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];

    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  stall_q, stall_d;
    logic                  we_q, we_d;
    logic [4:0]            waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic fifo_empty;
    logic fifo_full;
    logic main_wr;
    logic accept;
    logic pop;
    logic push;
    logic bypass;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

    // Readiness depends only on current occupancy. A slot freed by a pop
    // this cycle is offered from the next cycle onward.
    assign mdu_ready = reset && !fifo_full;

    // Writes to r0 are treated as no write at all.
    assign main_wr = wb_valid && (wb_addr != 5'd0);
    assign accept  = mdu_valid && mdu_ready && (mdu_addr != 5'd0);
    assign pop     = !fifo_empty && !main_wr;

`ifdef WB_MDU_BYPASS_EN
    assign bypass = fifo_empty && !main_wr && accept;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        stall_d  = stall_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        // Output-stage source select: main write, then FIFO head, then bypass.
        if (main_wr) begin
            we_d    = 1'b1;
            waddr_d = wb_addr;
            wdata_d = wb_data;
        end else if (pop) begin
            we_d    = 1'b1;
            waddr_d = mem_addr[rd_ptr_q];
            wdata_d = mem_data[rd_ptr_q];
        end else if (bypass) begin
            we_d    = 1'b1;
            waddr_d = mdu_addr;
            wdata_d = mdu_data;
        end

        // The pointers wrap naturally because FIFO_DEPTH is a power of 2.
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The counter saturates at the limit. While it is held there,
        // stall_req stays high until a pop finally happens.
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end

        if (pop) begin
            stall_d = 1'b0;
        end else if (starve_d == SW'(STARVE_LIMIT)) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= mdu_addr;
            mem_data[wr_ptr_q] <= mdu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign RegWrite      = we_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign mdu_pending   = !fifo_empty;
    assign fifo_count    = count_q;
    assign stall_req     = stall_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;

    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int LIMIT   = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wb_valid = 1'b0;
    logic [4:0]    wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          mdu_valid = 1'b0;
    logic          mdu_ready;
    logic [4:0]    mdu_addr = '0;
    logic [DW-1:0] mdu_data = '0;
    logic          RegWrite;
    logic [4:0]    write_address;
    logic [DW-1:0] write_data;
    logic          mdu_pending;
    logic [2:0]    fifo_count;
    logic          stall_req;

    reg_writeback_arbiter #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_addr     (mdu_addr),
        .mdu_data     (mdu_data),
        .RegWrite     (RegWrite),
        .write_address(write_address),
        .write_data   (write_data),
        .mdu_pending  (mdu_pending),
        .fifo_count   (fifo_count),
        .stall_req    (stall_req)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. The queue holds {addr, data} of results waiting for
    // the port. The exp_* values are what the DUT should show after the edge.
    logic [36:0]   q[$];
    logic          exp_we;
    logic [4:0]    exp_addr;
    logic [DW-1:0] exp_data;
    int            starve;
    logic          exp_stall;
    int            n_txn;

    function automatic void model_reset();
        q.delete();
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        starve    = 0;
        exp_stall = 1'b0;
    endfunction

    function automatic void model_step(input logic wv, input logic [4:0] wa, input logic [DW-1:0] wd,
                                       input logic mv, input logic [4:0] ma, input logic [DW-1:0] md);
        bit main_w, taken, use_byp, drained, was_empty;
        logic [36:0] head;
        main_w    = wv && (wa != 0);
        was_empty = (q.size() == 0);
        taken     = mv && (q.size() < DEPTH) && (ma != 0);
        drained   = !was_empty && !main_w;
`ifdef WB_MDU_BYPASS_EN
        use_byp   = was_empty && !main_w && taken;
`else
        use_byp   = 1'b0;
`endif
        exp_we = 1'b1;
        if (main_w) begin
            exp_addr = wa;
            exp_data = wd;
        end else if (drained) begin
            head     = q.pop_front();
            exp_addr = head[36:32];
            exp_data = head[31:0];
        end else if (use_byp) begin
            exp_addr = ma;
            exp_data = md;
        end else begin
            exp_we = 1'b0;
        end
        if (drained || was_empty) starve = 0;
        else if (starve < LIMIT) starve = starve + 1;
        if (drained) exp_stall = 1'b0;
        else if (starve == LIMIT) exp_stall = 1'b1;
        if (taken && !use_byp) q.push_back({ma, md});
    endfunction

    task automatic check_outputs();
        check_eq("RegWrite", RegWrite, exp_we);
        check_eq("write_address", write_address, exp_addr);
        check_eq("write_data", write_data, exp_data);
        check_eq("fifo_count", fifo_count, q.size());
        check_eq("mdu_pending", mdu_pending, q.size() != 0);
        check_eq("mdu_ready", mdu_ready, q.size() < DEPTH);
        check_eq("stall_req", stall_req, exp_stall);
    endtask

    // One bus cycle: check the registered state at the negedge, drive the
    // new inputs, then advance the model past the coming rising edge.
    task automatic step(input logic wv, input logic [4:0] wa, input logic [DW-1:0] wd,
                        input logic mv, input logic [4:0] ma, input logic [DW-1:0] md);
        @(negedge clk);
        check_outputs();
        wb_valid  = wv;
        wb_addr   = wa;
        wb_data   = wd;
        mdu_valid = mv;
        mdu_addr  = ma;
        mdu_data  = md;
        model_step(wv, wa, wd, mv, ma, md);
        n_txn++;
        $display("txn %0d: wb=%0b/%0d/%08h mdu=%0b/%0d/%08h q=%0d exp_we=%0b", n_txn, wv, wa, wd, mv, ma, md,
                 q.size(), exp_we);
    endtask

    task automatic check_reset_zero(input string tag);
        check_eq({tag, "_we"}, RegWrite, 1'b0);
        check_eq({tag, "_addr"}, write_address, 5'd0);
        check_eq({tag, "_data"}, write_data, 32'd0);
        check_eq({tag, "_cnt"}, fifo_count, 3'd0);
        check_eq({tag, "_pend"}, mdu_pending, 1'b0);
        check_eq({tag, "_stall"}, stall_req, 1'b0);
        check_eq({tag, "_rdy"}, mdu_ready, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        check_outputs();
        wb_valid  = 1'b0;
        mdu_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check_reset_zero("rst_mid");
        model_reset();
        @(negedge clk);
        check_reset_zero("rst_hold");
        reset = 1'b1;
        $display("txn reset pulse done");
    endtask

    initial begin
        int pw, pm;
        logic wv, mv;
        logic [4:0] wa, ma;
        n_txn = 0;
        model_reset();
        #1;
        check_reset_zero("rst_init");
        @(negedge clk);
        reset = 1'b1;

        // Main write and r0 write.
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        step(1, 5'd0, 32'h12345678, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Two MDU results with the pipe idle.
        step(0, 0, 0, 1, 5'd7, 32'h11);
        step(0, 0, 0, 1, 5'd9, 32'h22);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Starvation: main pipe hogs the port while the MDU offers 5 results.
        for (int i = 0; i < 14; i++) step(1, 5'd3, 32'hA000 + i, i < 5, 5'd10 + 5'(i), 32'hB000 + i);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 5'd20, 32'hC000 + i);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
        // Steady occupancy with simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 21; i++) step(0, 0, 0, 1, 5'(1 + i % 31), 32'hD000 + i);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        // Queue 3 results, then reset mid-drain.
        for (int i = 0; i < 3; i++) step(1, 5'd4, 32'hE000 + i, 1, 5'd12, 32'hF000 + i);
        step(0, 0, 0, 0, 0, 0);
        pulse_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);

        // Randomized phases with different main/MDU load mixes.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin pw = 30; pm = 50; end
                1: begin pw = 80; pm = 60; end
                2: begin pw = 97; pm = 90; end
                default: begin pw = 10; pm = 25; end
            endcase
            for (int i = 0; i < 300; i++) begin
                wv = ($urandom_range(0, 99) < pw);
                if (exp_stall && $urandom_range(0, 9) != 0) wv = 1'b0;
                wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mv = ($urandom_range(0, 99) < pm);
                ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                step(wv, wa, $urandom, mv, ma, $urandom);
            end
            if (ph == 1) pulse_reset();
        end
        step(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/reg_writeback_arbiter.md
# reg_writeback_arbiter

Write-side initiator for the CPU's 32-entry register file. It merges two result streams, the single-cycle main pipeline writeback and the multi-cycle multiply/divide unit (MDU), into the register file's single write port (`RegWrite`, `write_address`, `write_data`). MDU results are buffered in a small FIFO and drained when the main pipeline leaves the port idle. A starvation guard requests a main-pipe stall when the FIFO cannot drain.

## Interface
Parameters:
- DATA_WIDTH, 32, width of write data.
- FIFO_DEPTH, 4, MDU result FIFO entries; power of 2, ≥2.
- STARVE_LIMIT, 8, consecutive blocked drain cycles before `stall_req` is raised; ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_valid  in  1  main-pipe write request this cycle; always accepted, with no back-pressure.
- wb_addr  in  5  main-pipe destination register.
- wb_data  in  DATA_WIDTH  main-pipe result.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  MDU result accepted this cycle when high with `mdu_valid`.
- mdu_addr  in  5  MDU destination register.
- mdu_data  in  DATA_WIDTH  MDU result.
- RegWrite  out  1  register-file write enable, registered.
- write_address  out  5  register-file write index, registered.
- write_data  out  DATA_WIDTH  register-file write data, registered.
- mdu_pending  out  1  FIFO non-empty; consumed by the hazard unit.
- fifo_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
- stall_req  out  1  registered request that the main pipe hold `wb_valid`=0.

## Operation
- Reset asserted (low): FIFO empty, starve counter 0, and `RegWrite`, `write_address`, `write_data`, `stall_req`, `fifo_count`, `mdu_pending` all 0. `mdu_ready`=0 while reset is low.
- `mdu_ready` = reset high AND FIFO not full. It is combinational from occupancy and does not depend on `mdu_valid`.
- MDU accept: `mdu_valid && mdu_ready`.
  - `mdu_addr`==0: the result is discarded and is not pushed.
  - Otherwise the result is pushed at the next edge.
- Main write: `wb_valid && wb_addr!=0` drives the output stage at the next edge.
  - A write to register 0 never asserts `RegWrite`. It is treated as an idle port.
- Drain: when the FIFO is non-empty and there is no effective main write this cycle, the head is popped and loaded into the output stage at the same edge.
- Port priority: an effective main write beats a FIFO pop. A FIFO pop beats the bypass path (see Configuration).
- If no write source is selected in a cycle, `RegWrite`=0 next cycle. `write_address` and `write_data` hold their last values.
- Simultaneous push and pop in one cycle: allowed. Occupancy is unchanged. A pop at full frees a slot visible the following cycle.
- FIFO order is strictly in order. Wrap-around of the read and write pointers must not corrupt ordering or occupancy.
- Starvation guard:
  - The counter increments each cycle where the FIFO is non-empty and no pop occurs. It clears on any pop or when the FIFO is empty.
  - `stall_req` sets at the edge where the counter reaches STARVE_LIMIT. It clears at the edge after the next pop.
  - While `stall_req`=1 the main pipe guarantees `wb_valid`=0, so a pop is guaranteed the same cycle.
  - If `wb_valid`=1 with a nonzero address arrives anyway while `stall_req`=1, it still wins. No data is dropped and `stall_req` stays high.
- Write-after-write ordering between in-flight MDU results and main writes to the same register is the hazard unit's job, using `mdu_pending`. This block does not reorder.

## Timing
- Main write: request in cycle t; `RegWrite`=1 with the matching address/data throughout cycle t+1. The register file commits at the end of t+1.
- MDU result via FIFO: accepted in cycle t, occupies the FIFO from t+1. At the earliest it is popped in t+1 and appears on the port in t+2.
- Back-to-back main writes produce `RegWrite`=1 on consecutive cycles with no gaps.
- Reset mid-operation: asynchronous clear. Queued MDU results are lost; the MDU is reset by the same signal.

## Configuration
- `WB_MDU_BYPASS_EN` defined: if the FIFO is empty, there is no effective main write, and an MDU result is accepted in cycle t (address ≠0), it goes straight to the output stage in t+1 and is not pushed. Latency is 1.
- `WB_MDU_BYPASS_EN` undefined: every MDU result passes through the FIFO. Latency is at least 2.

## Test plan
- Reset, then `wb_valid`=1, `wb_addr`=5, `wb_data`=0xDEADBEEF in cycle t → `RegWrite`=1, `write_address`=5, `write_data`=0xDEADBEEF in cycle t+1 only. `wb_addr`=0 → `RegWrite` stays 0.
- With the main pipe idle, push MDU {addr 7, 0x11}, {addr 9, 0x22} on consecutive cycles:
  - Macro off: writes appear in t+2 and t+3, in order.
  - Macro on: writes appear in t+1 and t+2.
- Hold `wb_valid`=1 to reg 3 continuously and offer 5 MDU results with FIFO_DEPTH=4 → `mdu_ready` drops after 4 accepts and `fifo_count`=4. `stall_req` rises when the counter reaches 8, the edge after 8 blocked cycles with the FIFO non-empty. Drop `wb_valid` → 4 writes drain in order, `stall_req` clears after the first pop, and the fifth result is accepted.
- Keep the FIFO at steady occupancy 1 with simultaneous push and pop for 20 cycles, crossing pointer wrap → all 20 results are written in order and `fifo_count` stays 1.
- Queue 3 MDU results, then pulse reset low mid-drain → all outputs are 0 immediately, `fifo_count`=0, `mdu_ready`=0 while low, and no queued write appears after release.
